// File: rtl/vend_pkg.sv
// Shared types and widths for the vending panel / dispenser blocks.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_WAIT_DROP,
    S_CHANGE,
    S_DONE,
    S_FAIL
  } state_t;

  // Panel indices; also used as the last-served pointer encoding.
  localparam logic PANEL0 = 1'b0;
  localparam logic PANEL1 = 1'b1;

  // Product code and change count widths, shared with the coin/selection FSMs.
  localparam int PROD_W = 2;
  localparam int CHG_W  = 2;

  // Panel index to one-hot panel vector.
  function automatic logic [1:0] panel_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker. On a tie the panel not served last wins;
// the last-served pointer moves only when the owner strobes upd on a grant.
module rr_arbiter2
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       win
);

  logic last;

  // Winner: a lone requester wins, a tie goes to the panel not served last.
  always_comb begin
    win = PANEL0;
    if (req == 2'b10)      win = PANEL1;
    else if (req == 2'b11) win = ~last;
  end

  // Last-served pointer; reset to panel 1 so panel 0 takes the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     last <= PANEL1;
    else if (upd) last <= win;
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one dispenser motor and one coin ejector between two vending panels.
// Sequence per grant: motor pulse, wait for drop sensor (with timeout),
// eject change coins one at a time, then pulse done or err to the panel.
// Optional feature: define VEND_RETRY_EN to give each transaction one extra
// motor pulse after its first drop timeout.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int EJECT_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [PROD_W-1:0] prod0,
  input  logic [PROD_W-1:0] prod1,
  input  logic [CHG_W-1:0]  chg0,
  input  logic [CHG_W-1:0]  chg1,
  input  logic              drop_det,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic              motor_en,
  output logic [PROD_W-1:0] motor_sel,
  output logic              coin_eject,
  output logic              busy
);

  // One shared counter serves the motor pulse, drop wait and coin phases.
  localparam int MAX_A = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > EJECT_CYCLES + 1) ? MAX_A : EJECT_CYCLES + 1;
  localparam int CW    = $clog2(MAX_C) + 1;

  state_t            state, nxt;
  logic [CW-1:0]     cnt, cnt_d;
  logic [CHG_W-1:0]  coin, coin_d;
  logic              sel;
  logic [PROD_W-1:0] prod_q;
  logic [CHG_W-1:0]  chg_q;
  logic              win;
  logic              grant;
`ifdef VEND_RETRY_EN
  logic              retry, retry_d;
`endif

  assign grant = (state == S_IDLE) && (|req);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .upd (grant),
    .win (win)
  );

  // Next state and counter updates.
  always_comb begin
    nxt    = state;
    cnt_d  = cnt;
    coin_d = coin;
`ifdef VEND_RETRY_EN
    retry_d = retry;
`endif
    case (state)
      S_IDLE: begin
        cnt_d  = '0;
        coin_d = '0;
`ifdef VEND_RETRY_EN
        retry_d = 1'b0;
`endif
        if (|req) nxt = S_VEND;
      end
      S_VEND: begin
        if (cnt == CW'(PULSE_CYCLES - 1)) begin
          nxt   = S_WAIT_DROP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WAIT_DROP: begin
        if (drop_det) begin
          nxt   = (chg_q == '0) ? S_DONE : S_CHANGE;
          cnt_d = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d = '0;
`ifdef VEND_RETRY_EN
          if (!retry) begin
            nxt     = S_VEND;
            retry_d = 1'b1;
          end else begin
            nxt = S_FAIL;
          end
`else
          nxt = S_FAIL;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_CHANGE: begin
        // Each coin: EJECT_CYCLES high then one low cycle.
        if (cnt == CW'(EJECT_CYCLES)) begin
          cnt_d = '0;
          if (coin == chg_q - 1'b1) nxt = S_DONE;
          else                      coin_d = coin + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      S_FAIL:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      coin  <= '0;
`ifdef VEND_RETRY_EN
      retry <= 1'b0;
`endif
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
      coin  <= coin_d;
`ifdef VEND_RETRY_EN
      retry <= retry_d;
`endif
    end
  end

  // Latch the winner's request on grant; held until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel    <= PANEL0;
      prod_q <= '0;
      chg_q  <= '0;
    end else if (grant) begin
      sel    <= win;
      prod_q <= win ? prod1 : prod0;
      chg_q  <= win ? chg1  : chg0;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy       = (state != S_IDLE);
    gnt        = busy ? panel_onehot(sel) : 2'b00;
    motor_en   = (state == S_VEND);
    motor_sel  = motor_en ? prod_q : '0;
    coin_eject = (state == S_CHANGE) && (cnt < CW'(EJECT_CYCLES));
    done       = (state == S_DONE) ? panel_onehot(sel) : 2'b00;
    err        = (state == S_FAIL) ? panel_onehot(sel) : 2'b00;
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter with default parameters.
module tb_vend_dispense_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] prod0 = '0, prod1 = '0, chg0 = '0, chg1 = '0;
  logic       drop_det = 1'b0;
  logic [1:0] gnt, done, err, motor_sel;
  logic       motor_en, coin_eject, busy;

  int tests = 0;
  int fails = 0;

  vend_dispense_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .prod0      (prod0),
    .prod1      (prod1),
    .chg0       (chg0),
    .chg1       (chg1),
    .drop_det   (drop_det),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .motor_en   (motor_en),
    .motor_sel  (motor_sel),
    .coin_eject (coin_eject),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " motor"}, 32'(motor_en), 0);
    chk({tag, " coin"}, 32'(coin_eject), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " err"}, 32'(err), 0);
  endtask

  // Walk one transaction from cycle 1 (first VEND cycle) to end_c (done/err
  // cycle) plus one IDLE cycle. Masks give hand-computed motor/coin cycles.
  task automatic run(input string tag, input int pnl, input logic [1:0] psel,
                     input int drop_at, input int end_c, input bit is_err,
                     input logic [63:0] mmask, input logic [63:0] cmask,
                     input logic [1:0] clr);
    logic [1:0] oh;
    oh = (pnl == 1) ? 2'b10 : 2'b01;
    for (int k = 1; k <= end_c + 1; k++) begin
      tick();
      chk($sformatf("%s c%0d motor_en", tag, k), 32'(motor_en), 32'(mmask[k]));
      if (mmask[k]) chk($sformatf("%s c%0d motor_sel", tag, k), 32'(motor_sel), 32'(psel));
      chk($sformatf("%s c%0d coin", tag, k), 32'(coin_eject), 32'(cmask[k]));
      chk($sformatf("%s c%0d gnt", tag, k), 32'(gnt), (k <= end_c) ? 32'(oh) : 0);
      chk($sformatf("%s c%0d busy", tag, k), 32'(busy), (k <= end_c) ? 1 : 0);
      chk($sformatf("%s c%0d done", tag, k), 32'(done), (k == end_c && !is_err) ? 32'(oh) : 0);
      chk($sformatf("%s c%0d err", tag, k), 32'(err), (k == end_c && is_err) ? 32'(oh) : 0);
      if (k == drop_at) drop_det = 1'b1;
      if (k == end_c) begin
        drop_det = 1'b0;
        req = req & ~clr;
      end
    end
  endtask

  initial begin
    // Reset held: everything quiet.
    tick(); tick();
    chk_idle("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end

    // Single panel 0: prod 2, two coins, drop in third WAIT_DROP cycle.
    prod0 = 2'd2; chg0 = 2'd2; req = 2'b01;
    run("p0_chg2", 0, 2'd2, 7, 14, 0, 64'h1E, 64'h1B00, 2'b01);

    // Both request: panel 0 first, panel 1 in the IDLE after done[0].
    prod0 = 2'd1; chg0 = 2'd0; prod1 = 2'd3; chg1 = 2'd1;
    rst = 1'b0; tick(); rst = 1'b1;
    req = 2'b11;
    run("tie_p0", 0, 2'd1, 5, 6, 0, 64'h1E, 64'h0, 2'b01);
    run("tie_p1", 1, 2'd3, 5, 9, 0, 64'h1E, 64'hC0, 2'b10);
    req = 2'b11;
    run("rr_p0", 0, 2'd1, 5, 6, 0, 64'h1E, 64'h0, 2'b11);

    // Timeout, no drop, three coins owed: no coin ever ejected.
    prod0 = 2'd1; chg0 = 2'd3; req = 2'b01;
`ifdef VEND_RETRY_EN
    run("timeout", 0, 2'd1, 0, 41, 1, 64'h0000_0000_01E0_001E, 64'h0, 2'b01);
`else
    run("timeout", 0, 2'd1, 0, 21, 1, 64'h1E, 64'h0, 2'b01);
`endif

    // Minimum transaction on panel 1.
    prod1 = 2'd2; chg1 = 2'd0; req = 2'b10;
    run("min_p1", 1, 2'd2, 5, 6, 0, 64'h1E, 64'h0, 2'b10);

    // Reset in the middle of CHANGE.
    prod0 = 2'd2; chg0 = 2'd2; req = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) drop_det = 1'b1;
    end
    drop_det = 1'b0;
    chk("pre_rst coin", 32'(coin_eject), 1);
    tick();
    rst = 1'b0;
    #1;
    chk("async_rst coin", 32'(coin_eject), 0);
    chk("async_rst gnt", 32'(gnt), 0);
    chk("async_rst busy", 32'(busy), 0);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("rst_hold%0d", i));
    end
    rst = 1'b1;
    tick();
    chk_idle("post_rst");
    req = 2'b01;
    run("after_rst", 0, 2'd2, 5, 12, 0, 64'h1E, 64'h6C0, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
